// File: rtl/vblank_bus_sequencer.sv
// vblank_bus_sequencer
//   Programmable vblank bus master. On each vsync rising edge it runs a small
//   script of bus operations (load, store acc, store immediate, add immediate,
//   auto-increment store) against the shared video/RAM bus. It sits between the
//   frame timing generator and the system bus mux.
//
//   Optional feature macro: SEQ_DONE_IRQ_EN adds the 'done' output, a one-cycle
//   pulse when a script run completes normally (END or last entry). It does not
//   pulse when a run is aborted.
//
// Ports
//   clk       system clock
//   reset     asynchronous active-low reset
//   vsync     vertical blank level from the timing generator
//   addr      bus address
//   data      bus write data
//   din       bus read data, valid when ack=1
//   rw        1=write, 0=read, qualified by req (0 whenever req=0)
//   req       bus request, held until ack
//   ack       bus acknowledge, completes the transfer in that cycle
//   cfg_we    script entry write strobe (ignored while busy)
//   cfg_idx   script entry index
//   cfg_op    entry opcode
//   cfg_addr  entry address
//   cfg_imm   entry immediate
//   busy      script running (FETCH or BUS)
//   acc       accumulator, for observation
//   done      (SEQ_DONE_IRQ_EN only) run-complete pulse
module vblank_bus_sequencer #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter int NSTEPS = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      vsync,
   output logic [ADDR_W-1:0]         addr,
   output logic [DATA_W-1:0]         data,
   input  logic [DATA_W-1:0]         din,
   output logic                      rw,
   output logic                      req,
   input  logic                      ack,
   input  logic                      cfg_we,
   input  logic [$clog2(NSTEPS)-1:0] cfg_idx,
   input  logic [2:0]                cfg_op,
   input  logic [ADDR_W-1:0]         cfg_addr,
   input  logic [DATA_W-1:0]         cfg_imm,
   output logic                      busy,
   output logic [DATA_W-1:0]         acc
`ifdef SEQ_DONE_IRQ_EN
   ,
   output logic                      done
`endif
);

   localparam int IDX_W = $clog2(NSTEPS);

   localparam logic [2:0] OP_END   = 3'b000;
   localparam logic [2:0] OP_LOAD  = 3'b001;
   localparam logic [2:0] OP_STA   = 3'b010;
   localparam logic [2:0] OP_STI   = 3'b011;
   localparam logic [2:0] OP_ADDI  = 3'b100;
   localparam logic [2:0] OP_STINC = 3'b101;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_BUS, S_DONE} state_t;

   state_t              state, state_nx;
   logic [IDX_W-1:0]    pc, pc_nx;
   logic [2:0]          cur_op, cur_op_nx;
   logic [ADDR_W-1:0]   addr_nx;
   logic [DATA_W-1:0]   data_nx;
   logic [DATA_W-1:0]   acc_nx;
   logic                rw_nx, req_nx;
   logic                vsync_q;
   logic                start, last, stinc_wb;

   logic [2:0]          op_mem   [NSTEPS];
   logic [ADDR_W-1:0]   addr_mem [NSTEPS];
   logic [DATA_W-1:0]   imm_mem  [NSTEPS];

   logic [2:0]          e_op;
   logic [ADDR_W-1:0]   e_addr;
   logic [DATA_W-1:0]   e_imm;

   // Modulo-2^DATA_W add; overflow wraps silently.
   function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
      return a + b;
   endfunction

   assign start  = vsync & ~vsync_q;
   assign last   = (pc == IDX_W'(NSTEPS - 1));
   assign busy   = (state == S_FETCH) || (state == S_BUS);
   assign e_op   = op_mem[pc];
   assign e_addr = addr_mem[pc];
   assign e_imm  = imm_mem[pc];
   // A STINC entry is bumped only when its transfer actually completes.
   assign stinc_wb = (state == S_BUS) && vsync && ack && (cur_op == OP_STINC);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         pc      <= '0;
         cur_op  <= OP_END;
         addr    <= '0;
         data    <= '0;
         rw      <= 1'b0;
         req     <= 1'b0;
         acc     <= '0;
         vsync_q <= 1'b0;
      end else begin
         state   <= state_nx;
         pc      <= pc_nx;
         cur_op  <= cur_op_nx;
         addr    <= addr_nx;
         data    <= data_nx;
         rw      <= rw_nx;
         req     <= req_nx;
         acc     <= acc_nx;
         vsync_q <= vsync;
      end
   end

   always_comb begin
      state_nx  = state;
      pc_nx     = pc;
      cur_op_nx = cur_op;
      addr_nx   = addr;
      data_nx   = data;
      rw_nx     = rw;
      req_nx    = req;
      acc_nx    = acc;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx = S_FETCH;
               pc_nx    = '0;
            end
         end
         S_FETCH: begin
            if (!vsync) begin
               state_nx = S_IDLE;
               req_nx   = 1'b0;
               rw_nx    = 1'b0;
            end else begin
               case (e_op)
                  OP_LOAD, OP_STA, OP_STI, OP_STINC: begin
                     state_nx  = S_BUS;
                     cur_op_nx = e_op;
                     addr_nx   = e_addr;
                     data_nx   = (e_op == OP_STA) ? acc : e_imm;
                     rw_nx     = (e_op != OP_LOAD);
                     req_nx    = 1'b1;
                  end
                  OP_ADDI: begin
                     acc_nx = wrap_add(acc, e_imm);
                     if (last) state_nx = S_DONE;
                     else      pc_nx    = pc + IDX_W'(1);
                  end
                  default: state_nx = S_DONE;
               endcase
            end
         end
         S_BUS: begin
            // Abort drops the request; the interrupted op is not replayed.
            if (!vsync) begin
               state_nx = S_IDLE;
               req_nx   = 1'b0;
               rw_nx    = 1'b0;
            end else if (ack) begin
               req_nx = 1'b0;
               rw_nx  = 1'b0;
               if (cur_op == OP_LOAD) acc_nx = din;
               if (last) begin
                  state_nx = S_DONE;
               end else begin
                  pc_nx    = pc + IDX_W'(1);
                  state_nx = S_FETCH;
               end
            end
         end
         S_DONE: begin
            if (!vsync) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Script table. The busy gate keeps host writes and STINC writeback apart.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NSTEPS; i++) begin
            op_mem[i]   <= OP_END;
            addr_mem[i] <= '0;
            imm_mem[i]  <= '0;
         end
      end else if (stinc_wb) begin
         imm_mem[pc] <= wrap_add(imm_mem[pc], DATA_W'(1));
      end else if (cfg_we && !busy) begin
         op_mem[cfg_idx]   <= cfg_op;
         addr_mem[cfg_idx] <= cfg_addr;
         imm_mem[cfg_idx]  <= cfg_imm;
      end
   end

`ifdef SEQ_DONE_IRQ_EN
   // Only FETCH/BUS completions enter DONE, so any entry into DONE is a
   // normal finish; aborts go to IDLE and never pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) done <= 1'b0;
      else        done <= (state_nx == S_DONE) && (state != S_DONE);
   end
`endif

endmodule
